// File: rtl/core_ex_muldiv_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// RV32M/RV64M funct3 op codes, FSM state encoding and op-decode helpers.
package core_ex_muldiv_iter_pkg;

  // funct3 encodings of the M-extension ops
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } md_state_e;

  // Operand A is interpreted as signed (converted to a magnitude on accept)
  function automatic logic op_a_signed(input logic [2:0] op);
    logic r;
    case (op)
      OP_MULH, OP_MULHSU, OP_DIV, OP_REM: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  // Operand B is interpreted as signed (converted to a magnitude on accept)
  function automatic logic op_b_signed(input logic [2:0] op);
    logic r;
    case (op)
      OP_MULH, OP_DIV, OP_REM: r = 1'b1;
      default:                 r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/core_ex_muldiv_iter_step.sv
// One radix-2 iteration of the shared mul/div datapath.
// Multiply: {hi,lo} is the product register; if lo[0] add b into hi, then
// shift the whole register right by one (carry enters hi msb).
// Divide: hi is the partial remainder, lo the dividend/quotient; shift
// {hi,lo} left by one, trial-subtract b, keep the difference when it does
// not borrow and shift the quotient bit into lo.
module core_ex_muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            div_mode_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0] sum_s;
  logic [XLEN:0] shl_s;
  logic [XLEN:0] diff_s;

  // Single shift-add / restoring-subtract step
  always_comb begin
    sum_s  = {1'b0, hi_i} + {1'b0, b_i};
    shl_s  = {hi_i, lo_i[XLEN-1]};
    diff_s = shl_s - {1'b0, b_i};
    hi_o   = hi_i;
    lo_o   = lo_i;
    if (div_mode_i) begin
      // remainder < divisor keeps the difference within XLEN+1 signed range
      if (!diff_s[XLEN]) begin
        hi_o = diff_s[XLEN-1:0];
        lo_o = {lo_i[XLEN-2:0], 1'b1};
      end else begin
        hi_o = shl_s[XLEN-1:0];
        lo_o = {lo_i[XLEN-2:0], 1'b0};
      end
    end else begin
      if (lo_i[0]) begin
        hi_o = sum_s[XLEN:1];
        lo_o = {sum_s[0], lo_i[XLEN-1:1]};
      end else begin
        hi_o = {1'b0, hi_i[XLEN-1:1]};
        lo_o = {hi_i[0], lo_i[XLEN-1:1]};
      end
    end
  end

endmodule

// File: rtl/core_ex_muldiv_iter.sv
// Iterative RV32M/RV64M multiply/divide unit for the execute stage.
// Retires UNROLL radix-2 steps per cycle (UNROLL in {1,2,4}, dividing XLEN).
// Divide-by-zero and signed overflow complete without iterating.
module core_ex_muldiv_iter
  import core_ex_muldiv_iter_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5,
  parameter int UNROLL      = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_op,
  input  logic [XLEN-1:0]        in_rs1,
  input  logic [XLEN-1:0]        in_rs2,
  input  logic [RFIDX_WIDTH-1:0] in_rd_idx,
  input  logic                   in_rd_wen,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_result,
  output logic [RFIDX_WIDTH-1:0] out_rd_idx,
  output logic                   out_rd_wen,
  output logic                   busy,
  output logic [RFIDX_WIDTH-1:0] busy_rd_idx,
  output logic                   busy_rd_wen
);

  localparam int N     = XLEN / UNROLL;
  localparam int CNT_W = $clog2(N + 1);

  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(N);
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]   ONE_X    = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [2*XLEN-1:0] ONE_2X   = {{(2*XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]   MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]   ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]   ZERO_X   = {XLEN{1'b0}};

  md_state_e state_q, state_d;

  logic [2:0]             op_q, op_d;
  logic [RFIDX_WIDTH-1:0] rd_idx_q, rd_idx_d;
  logic                   rd_wen_q, rd_wen_d;
  logic                   neg_q, neg_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [XLEN-1:0]        hi_q, hi_d;
  logic [XLEN-1:0]        lo_q, lo_d;
  logic [XLEN-1:0]        b_q, b_d;
  logic [XLEN-1:0]        result_q, result_d;

  logic                   accept_s;
  logic                   a_neg_s;
  logic                   b_neg_s;
  logic [XLEN-1:0]        a_mag_s;
  logic [XLEN-1:0]        b_mag_s;
  logic                   div0_s;
  logic                   ovf_s;
  logic                   fast_s;
  logic [XLEN-1:0]        fast_res_s;
  logic                   last_step_s;
  logic [2*XLEN-1:0]      prod_s;
  logic [2*XLEN-1:0]      prod_fix_s;
  logic [XLEN-1:0]        quo_fix_s;
  logic [XLEN-1:0]        rem_fix_s;
  logic [XLEN-1:0]        final_res_s;

  logic [XLEN-1:0] chain_hi_s [0:UNROLL];
  logic [XLEN-1:0] chain_lo_s [0:UNROLL];

  assign chain_hi_s[0] = hi_q;
  assign chain_lo_s[0] = lo_q;

  genvar g;
  generate
    for (g = 0; g < UNROLL; g++) begin : g_step
      core_ex_muldiv_step #(.XLEN(XLEN)) u_step (
        .div_mode_i (op_q[2]),
        .hi_i       (chain_hi_s[g]),
        .lo_i       (chain_lo_s[g]),
        .b_i        (b_q),
        .hi_o       (chain_hi_s[g+1]),
        .lo_o       (chain_lo_s[g+1])
      );
    end
  endgenerate

  // Request decode: sign/magnitude conversion and fast-path detection
  always_comb begin
    accept_s = in_valid & (state_q == ST_IDLE) & ~flush;
    a_neg_s  = op_a_signed(in_op) & in_rs1[XLEN-1];
    b_neg_s  = op_b_signed(in_op) & in_rs2[XLEN-1];
    a_mag_s  = a_neg_s ? (~in_rs1 + ONE_X) : in_rs1;
    b_mag_s  = b_neg_s ? (~in_rs2 + ONE_X) : in_rs2;
    div0_s   = in_op[2] & (in_rs2 == ZERO_X);
    ovf_s    = ((in_op == OP_DIV) | (in_op == OP_REM)) &
               (in_rs1 == MIN_NEG) & (in_rs2 == ALL_ONES);
    fast_s   = div0_s | ovf_s;
    if (div0_s) begin
      fast_res_s = in_op[1] ? in_rs1 : ALL_ONES;
    end else if (ovf_s) begin
      fast_res_s = in_op[1] ? ZERO_X : in_rs1;
    end else begin
      fast_res_s = ZERO_X;
    end
  end

  // Result formatting after the final iteration: sign fix and half select
  always_comb begin
    last_step_s = (cnt_q == CNT_ONE);
    prod_s      = {chain_hi_s[UNROLL], chain_lo_s[UNROLL]};
    prod_fix_s  = neg_q ? (~prod_s + ONE_2X) : prod_s;
    quo_fix_s   = neg_q ? (~chain_lo_s[UNROLL] + ONE_X) : chain_lo_s[UNROLL];
    rem_fix_s   = neg_q ? (~chain_hi_s[UNROLL] + ONE_X) : chain_hi_s[UNROLL];
    case (op_q)
      OP_MUL:                        final_res_s = prod_fix_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  final_res_s = prod_fix_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               final_res_s = quo_fix_s;
      OP_REM, OP_REMU:               final_res_s = rem_fix_s;
      default:                       final_res_s = ZERO_X;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; flush returns to IDLE and wins over out_ready
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = fast_s ? ST_DONE : ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (last_step_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_DONE: begin
        if (flush | out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM output decode: handshake and hazard-tracking flags
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_CALC: busy     = 1'b1;
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
    busy_rd_wen = busy & rd_wen_q;
  end

  assign busy_rd_idx = rd_idx_q;
  assign out_result  = result_q;
  assign out_rd_idx  = rd_idx_q;
  assign out_rd_wen  = rd_wen_q;

  // Datapath next-state: latch request on accept, iterate while in CALC
  always_comb begin
    op_d     = op_q;
    rd_idx_d = rd_idx_q;
    rd_wen_d = rd_wen_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    result_d = result_q;
    if ((state_q == ST_IDLE) && accept_s) begin
      op_d     = in_op;
      rd_idx_d = in_rd_idx;
      rd_wen_d = in_rd_wen;
      // REM takes the dividend sign; MULH/DIV the xor; MULHSU has b_neg=0
      neg_d    = (in_op == OP_REM) ? a_neg_s : (a_neg_s ^ b_neg_s);
      hi_d     = ZERO_X;
      lo_d     = a_mag_s;
      b_d      = b_mag_s;
      if (fast_s) begin
        cnt_d    = {CNT_W{1'b0}};
        result_d = fast_res_s;
      end else begin
        cnt_d    = CNT_INIT;
        result_d = result_q;
      end
    end else if ((state_q == ST_CALC) && !flush) begin
      hi_d  = chain_hi_s[UNROLL];
      lo_d  = chain_lo_s[UNROLL];
      cnt_d = cnt_q - CNT_ONE;
      if (last_step_s) begin
        result_d = final_res_s;
      end else begin
        result_d = result_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= OP_MUL;
      rd_idx_q <= {RFIDX_WIDTH{1'b0}};
      rd_wen_q <= 1'b0;
      neg_q    <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
      hi_q     <= ZERO_X;
      lo_q     <= ZERO_X;
      b_q      <= ZERO_X;
      result_q <= ZERO_X;
    end else begin
      op_q     <= op_d;
      rd_idx_q <= rd_idx_d;
      rd_wen_q <= rd_wen_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_core_ex_muldiv_iter.sv
// Directed self-checking bench for core_ex_muldiv_iter: a 32-bit/UNROLL=1
// instance carries most vectors; 32-bit/UNROLL=4 and 64-bit/UNROLL=2
// instances check latency scaling.
module tb_core_ex_muldiv_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- DUT A: XLEN=32, UNROLL=1 ----------------
  logic        a_in_valid = 1'b0, a_in_ready, a_in_rd_wen = 1'b0, a_flush = 1'b0;
  logic [2:0]  a_in_op = 3'd0;
  logic [31:0] a_in_rs1 = 32'd0, a_in_rs2 = 32'd0, a_out_result;
  logic [4:0]  a_in_rd_idx = 5'd0, a_out_rd_idx, a_busy_rd_idx;
  logic        a_out_valid, a_out_ready = 1'b0, a_out_rd_wen, a_busy, a_busy_rd_wen;

  core_ex_muldiv_iter #(.XLEN(32), .RFIDX_WIDTH(5), .UNROLL(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_op(a_in_op), .in_rs1(a_in_rs1), .in_rs2(a_in_rs2),
    .in_rd_idx(a_in_rd_idx), .in_rd_wen(a_in_rd_wen), .flush(a_flush),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_result(a_out_result),
    .out_rd_idx(a_out_rd_idx), .out_rd_wen(a_out_rd_wen), .busy(a_busy),
    .busy_rd_idx(a_busy_rd_idx), .busy_rd_wen(a_busy_rd_wen)
  );

  // ---------------- DUT B: XLEN=32, UNROLL=4 ----------------
  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0;
  logic [2:0]  b_in_op = 3'd0;
  logic [31:0] b_in_rs1 = 32'd0, b_in_rs2 = 32'd0, b_out_result;
  logic [4:0]  b_out_rd_idx, b_busy_rd_idx;
  logic        b_out_rd_wen, b_busy, b_busy_rd_wen;

  core_ex_muldiv_iter #(.XLEN(32), .RFIDX_WIDTH(5), .UNROLL(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_op(b_in_op), .in_rs1(b_in_rs1), .in_rs2(b_in_rs2),
    .in_rd_idx(5'd3), .in_rd_wen(1'b1), .flush(1'b0),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_result(b_out_result),
    .out_rd_idx(b_out_rd_idx), .out_rd_wen(b_out_rd_wen), .busy(b_busy),
    .busy_rd_idx(b_busy_rd_idx), .busy_rd_wen(b_busy_rd_wen)
  );

  // ---------------- DUT C: XLEN=64, UNROLL=2 ----------------
  logic        c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b0;
  logic [2:0]  c_in_op = 3'd0;
  logic [63:0] c_in_rs1 = 64'd0, c_in_rs2 = 64'd0, c_out_result;
  logic [4:0]  c_out_rd_idx, c_busy_rd_idx;
  logic        c_out_rd_wen, c_busy, c_busy_rd_wen;

  core_ex_muldiv_iter #(.XLEN(64), .RFIDX_WIDTH(5), .UNROLL(2)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_op(c_in_op), .in_rs1(c_in_rs1), .in_rs2(c_in_rs2),
    .in_rd_idx(5'd12), .in_rd_wen(1'b1), .flush(1'b0),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_result(c_out_result),
    .out_rd_idx(c_out_rd_idx), .out_rd_wen(c_out_rd_wen), .busy(c_busy),
    .busy_rd_idx(c_busy_rd_idx), .busy_rd_wen(c_busy_rd_wen)
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one request to DUT A; returns at the negedge of cycle 1
  task automatic issue_a(input logic [2:0] op, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [4:0] rd);
    @(negedge clk);
    a_in_valid  = 1'b1;
    a_in_op     = op;
    a_in_rs1    = rs1;
    a_in_rs2    = rs2;
    a_in_rd_idx = rd;
    a_in_rd_wen = 1'b1;
    @(negedge clk);
    a_in_valid  = 1'b0;
  endtask

  // Wait (bounded) for out_valid on DUT A; cyc is the cycle index seen
  task automatic wait_a(output int cyc, output logic ready_seen);
    cyc = 1;
    ready_seen = 1'b0;
    while (!a_out_valid && cyc < 200) begin
      if (a_in_ready) ready_seen = 1'b1;
      @(negedge clk);
      cyc++;
    end
  endtask

  // Full transaction on DUT A with latency, result and handshake checks
  task automatic run_a(input string tag, input logic [2:0] op, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] exp, input int lat);
    int cyc;
    logic ready_seen;
    issue_a(op, rs1, rs2, 5'd9);
    wait_a(cyc, ready_seen);
    chk($sformatf("%s_lat", tag), 64'(cyc), 64'(lat));
    chk($sformatf("%s_res", tag), {32'd0, a_out_result}, {32'd0, exp});
    chk($sformatf("%s_rdy_busy", tag), {62'd0, ready_seen, a_in_ready}, 64'd0);
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    chk($sformatf("%s_idle", tag), {62'd0, a_in_ready, a_out_valid}, 64'd2);
  endtask

  initial begin
    int   cyc;
    logic ready_seen;
    logic seen_valid;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {63'd0, a_in_ready}, 64'd1);
    chk("rst_flags", {60'd0, a_out_valid, a_busy, a_busy_rd_wen, a_out_rd_wen}, 64'd0);
    chk("rst_result", {32'd0, a_out_result}, 64'd0);
    chk("rst_rd_idx", {59'd0, a_out_rd_idx}, 64'd0);
    rst = 1'b0;

    // multiply
    run_a("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_a("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_a("mulh",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
    run_a("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);

    // fast paths
    run_a("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_a("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    run_a("divu_z",   3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    run_a("remu_z",   3'b111, 32'd5,         32'd0,         32'd5,         1);
    run_a("div_z",    3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    run_a("rem_z",    3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1);

    // iterative divide
    run_a("div_n7_2", 3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    run_a("rem_n7_2", 3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    run_a("divu_100", 3'b101, 32'd100,       32'd7,         32'd14,        33);
    run_a("remu_100", 3'b111, 32'd100,       32'd7,         32'd2,         33);
    run_a("div_20_n3", 3'b100, 32'd20,       32'hFFFF_FFFD, 32'hFFFF_FFFA, 33);
    run_a("rem_20_n3", 3'b110, 32'd20,       32'hFFFF_FFFD, 32'd2,         33);

    // back-pressure: result and rd stay stable while out_ready is low
    issue_a(3'b011, 32'h0001_0000, 32'h0003_0000, 5'd17);
    wait_a(cyc, ready_seen);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {63'd0, a_out_valid}, 64'd1);
      chk("hold_res", {32'd0, a_out_result}, 64'h3);
      chk("hold_rd", {58'd0, a_out_rd_idx, a_busy_rd_idx[0]}, {58'd0, 5'd17, 1'b1});
      chk("hold_busy_rd_wen", {62'd0, a_busy_rd_wen, a_in_ready}, 64'd2);
      @(negedge clk);
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    chk("hold_release", {62'd0, a_in_ready, a_busy_rd_wen}, 64'd2);

    // flush in cycle 10 of a DIV
    issue_a(3'b101, 32'd1000, 32'd3, 5'd4);
    repeat (9) @(negedge clk);
    a_flush = 1'b1;
    @(negedge clk);
    a_flush = 1'b0;
    chk("flush_idle", {61'd0, a_busy, a_in_ready, a_out_valid}, 64'd2);
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (a_out_valid) seen_valid = 1'b1;
      @(negedge clk);
    end
    chk("flush_no_valid", {63'd0, seen_valid}, 64'd0);

    // flush in IDLE blocks the accept
    @(negedge clk);
    a_in_valid = 1'b1;
    a_in_op    = 3'b101;
    a_in_rs2   = 32'd0;
    a_flush    = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    a_flush    = 1'b0;
    chk("flush_idle_block", {62'd0, a_busy, a_out_valid}, 64'd0);

    // flush and out_ready together in DONE: flush wins, unit idles
    issue_a(3'b111, 32'd9, 32'd0, 5'd6);
    chk("fo_done", {63'd0, a_out_valid}, 64'd1);
    a_flush = 1'b1;
    a_out_ready = 1'b1;
    @(negedge clk);
    a_flush = 1'b0;
    a_out_ready = 1'b0;
    chk("fo_idle", {62'd0, a_out_valid, a_in_ready}, 64'd1);

    // reset in cycle 5 of a MUL
    issue_a(3'b000, 32'd123, 32'd456, 5'd21);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_flags", {59'd0, a_in_ready, a_out_valid, a_busy, a_busy_rd_wen, a_out_rd_wen}, 64'h10);
    chk("mrst_result", {32'd0, a_out_result}, 64'd0);
    chk("mrst_rd", {59'd0, a_out_rd_idx}, 64'd0);
    rst = 1'b0;

    // UNROLL=4: 8 iterations
    @(negedge clk);
    b_in_valid = 1'b1;
    b_in_op    = 3'b000;
    b_in_rs1   = 32'h1234_5678;
    b_in_rs2   = 32'h0000_0010;
    @(negedge clk);
    b_in_valid = 1'b0;
    cyc = 1;
    while (!b_out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("u4_lat", 64'(cyc), 64'd9);
    chk("u4_res", {32'd0, b_out_result}, 64'h2345_6780);
    chk("u4_rd", {57'd0, b_out_rd_idx, b_out_rd_wen, b_busy_rd_wen}, {57'd0, 5'd3, 2'b11});
    chk("u4_busy_rd", {58'd0, b_busy_rd_idx, b_busy}, {58'd0, 5'd3, 1'b1});
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    chk("u4_idle", {62'd0, b_in_ready, b_out_valid}, 64'd2);

    // XLEN=64, UNROLL=2: 32 iterations
    @(negedge clk);
    c_in_valid = 1'b1;
    c_in_op    = 3'b101;
    c_in_rs1   = 64'h8000_0000_0000_0000;
    c_in_rs2   = 64'd3;
    @(negedge clk);
    c_in_valid = 1'b0;
    cyc = 1;
    while (!c_out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("x64_lat", 64'(cyc), 64'd33);
    chk("x64_res", c_out_result, 64'h2AAA_AAAA_AAAA_AAAA);
    chk("x64_rd", {57'd0, c_out_rd_idx, c_out_rd_wen, c_busy_rd_wen}, {57'd0, 5'd12, 2'b11});
    chk("x64_busy_rd", {58'd0, c_busy_rd_idx, c_busy}, {58'd0, 5'd12, 1'b1});
    c_out_ready = 1'b1;
    @(negedge clk);
    c_out_ready = 1'b0;
    chk("x64_idle", {62'd0, c_in_ready, c_out_valid}, 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
